// File: rtl/store_buffer_gen2.sv
// store_buffer_gen2: circular store FIFO between the LSU data bus and the DCache, drained by a req/ack FSM.
// Define STB_LOAD_FWD_EN to add the store-to-load forwarding ports and comparators.
module store_buffer_gen2 #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_SEL_WIDTH = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [ADDR_WIDTH-1:0]              lsudbus2stb_addr,
   input  logic [DATA_WIDTH-1:0]              lsudbus2stb_wdata,
   input  logic [BYTE_SEL_WIDTH-1:0]          lsudbus2stb_sel_byte,
   input  logic                               lsudbus2stb_w_en,
   output logic                               stb2lsudbus_ack,
   output logic [ADDR_WIDTH-1:0]              stb2dcache_addr,
   output logic [DATA_WIDTH-1:0]              stb2dcache_wdata,
   output logic [BYTE_SEL_WIDTH-1:0]          stb2dcache_sel_byte,
   output logic                               stb2dcache_req,
   output logic                               stb2dcache_w_en,
   input  logic                               dcache2stb_ack,
   output logic                               stb_empty,
   output logic                               stb_full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    stb_count
`ifdef STB_LOAD_FWD_EN
   ,
   input  logic [ADDR_WIDTH-1:0]              lsudbus2stb_ld_addr,
   output logic                               stb2lsudbus_fwd_hit,
   output logic [DATA_WIDTH-1:0]              stb2lsudbus_fwd_data,
   output logic [BYTE_SEL_WIDTH-1:0]          stb2lsudbus_fwd_sel_byte
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [ADDR_WIDTH-1:0]     r_mem_addr [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]     r_mem_data [FIFO_DEPTH];
   logic [BYTE_SEL_WIDTH-1:0] r_mem_sel  [FIFO_DEPTH];
   logic [PTR_W-1:0]          r_wr_ptr;
   logic [PTR_W-1:0]          r_rd_ptr;
   logic [CNT_W-1:0]          r_count;
   logic [CNT_W-1:0]          w_count_nxt;
   logic                      r_ack;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_req;

   assign stb_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign stb_empty   = (r_count == '0);
   assign stb_count   = r_count;
   assign w_req       = (r_state == S_REQ);
   assign w_push      = lsudbus2stb_w_en && !stb_full;
   assign w_pop       = w_req && dcache2stb_ack;
   assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

   // NOTE: storage has no reset; only the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_addr[r_wr_ptr] <= lsudbus2stb_addr;
         r_mem_data[r_wr_ptr] <= lsudbus2stb_wdata;
         r_mem_sel[r_wr_ptr]  <= lsudbus2stb_sel_byte;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ack    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_ack    <= w_push;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (r_count != '0) w_state_nxt = S_REQ;
         S_REQ:   if (w_pop && (w_count_nxt == '0)) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign stb2lsudbus_ack     = r_ack;
   assign stb2dcache_req      = w_req;
   assign stb2dcache_w_en     = w_req;
   assign stb2dcache_addr     = w_req ? r_mem_addr[r_rd_ptr] : '0;
   assign stb2dcache_wdata    = w_req ? r_mem_data[r_rd_ptr] : '0;
   assign stb2dcache_sel_byte = w_req ? r_mem_sel[r_rd_ptr]  : '0;

`ifdef STB_LOAD_FWD_EN
   // Walk valid entries oldest to youngest so the youngest word match wins.
   always_comb begin
      logic [PTR_W-1:0] v_idx;
      stb2lsudbus_fwd_hit      = 1'b0;
      stb2lsudbus_fwd_data     = '0;
      stb2lsudbus_fwd_sel_byte = '0;
      v_idx                    = r_rd_ptr;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         v_idx = r_rd_ptr + PTR_W'(k);
         if ((CNT_W'(k) < r_count) &&
             (r_mem_addr[v_idx][ADDR_WIDTH-1:2] == lsudbus2stb_ld_addr[ADDR_WIDTH-1:2])) begin
            stb2lsudbus_fwd_hit      = 1'b1;
            stb2lsudbus_fwd_data     = r_mem_data[v_idx];
            stb2lsudbus_fwd_sel_byte = r_mem_sel[v_idx];
         end
      end
   end
`endif

endmodule

// File: tb/tb_store_buffer_gen2.sv
// tb_store_buffer_gen2: directed and randomized checks of store_buffer_gen2 against a queue-based model.
// Forwarding checks are compiled in when STB_LOAD_FWD_EN is defined.
module tb_store_buffer_gen2;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] lsudbus2stb_addr;
   logic [31:0] lsudbus2stb_wdata;
   logic [3:0]  lsudbus2stb_sel_byte;
   logic        lsudbus2stb_w_en;
   logic        stb2lsudbus_ack;
   logic [31:0] stb2dcache_addr;
   logic [31:0] stb2dcache_wdata;
   logic [3:0]  stb2dcache_sel_byte;
   logic        stb2dcache_req;
   logic        stb2dcache_w_en;
   logic        dcache2stb_ack;
   logic        stb_empty;
   logic        stb_full;
   logic [2:0]  stb_count;
   logic [31:0] ld_addr;
`ifdef STB_LOAD_FWD_EN
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic [3:0]  fwd_sel;
`endif

   int   n_checks = 0;
   int   n_pass   = 0;
   ent_t q[$];
   logic m_ack;
   logic m_req;

   store_buffer_gen2 #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_SEL_WIDTH(4), .FIFO_DEPTH(DEPTH)
   ) u_dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .lsudbus2stb_addr    (lsudbus2stb_addr),
      .lsudbus2stb_wdata   (lsudbus2stb_wdata),
      .lsudbus2stb_sel_byte(lsudbus2stb_sel_byte),
      .lsudbus2stb_w_en    (lsudbus2stb_w_en),
      .stb2lsudbus_ack     (stb2lsudbus_ack),
      .stb2dcache_addr     (stb2dcache_addr),
      .stb2dcache_wdata    (stb2dcache_wdata),
      .stb2dcache_sel_byte (stb2dcache_sel_byte),
      .stb2dcache_req      (stb2dcache_req),
      .stb2dcache_w_en     (stb2dcache_w_en),
      .dcache2stb_ack      (dcache2stb_ack),
      .stb_empty           (stb_empty),
      .stb_full            (stb_full),
      .stb_count           (stb_count)
`ifdef STB_LOAD_FWD_EN
      ,
      .lsudbus2stb_ld_addr     (ld_addr),
      .stb2lsudbus_fwd_hit     (fwd_hit),
      .stb2lsudbus_fwd_data    (fwd_data),
      .stb2lsudbus_fwd_sel_byte(fwd_sel)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      q.delete();
      m_ack = 1'b0;
      m_req = 1'b0;
   endtask

   // One clock cycle: drive inputs after the falling edge, compare against the model, then advance the model.
   task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic dack, input logic [31:0] ld);
      int   old_sz;
      logic push;
      logic pop;
      ent_t e;
      @(negedge clk);
      lsudbus2stb_w_en     = we;
      lsudbus2stb_addr     = a;
      lsudbus2stb_wdata    = d;
      lsudbus2stb_sel_byte = s;
      dcache2stb_ack       = dack;
      ld_addr              = ld;
      #1;
      check("count",   stb_count, q.size());
      check("empty",   stb_empty, q.size() == 0);
      check("full",    stb_full,  q.size() == DEPTH);
      check("lsu_ack", stb2lsudbus_ack, m_ack);
      check("req",     stb2dcache_req,  m_req);
      check("dc_w_en", stb2dcache_w_en, m_req);
      if (m_req) begin
         check("dc_addr", stb2dcache_addr,     q[0].a);
         check("dc_data", stb2dcache_wdata,    q[0].d);
         check("dc_sel",  stb2dcache_sel_byte, q[0].s);
      end else begin
         check("dc_addr_idle", stb2dcache_addr,     0);
         check("dc_data_idle", stb2dcache_wdata,    0);
         check("dc_sel_idle",  stb2dcache_sel_byte, 0);
      end
`ifdef STB_LOAD_FWD_EN
      begin
         logic        fh;
         logic [31:0] fd;
         logic [3:0]  fs;
         fh = 1'b0;
         fd = '0;
         fs = '0;
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a[31:2] == ld[31:2]) begin
               fh = 1'b1;
               fd = q[i].d;
               fs = q[i].s;
               break;
            end
         end
         check("fwd_hit", fwd_hit, fh);
         if (fh) begin
            check("fwd_data", fwd_data, fd);
            check("fwd_sel",  fwd_sel,  fs);
         end
      end
`endif
      // Req is high exactly when the buffer was non-empty in both the previous and the current cycle.
      old_sz = q.size();
      pop    = m_req && dack;
      push   = we && (old_sz < DEPTH);
      if (pop) void'(q.pop_front());
      if (push) begin
         e.a = a;
         e.d = d;
         e.s = s;
         q.push_back(e);
      end
      m_ack = push;
      m_req = (old_sz != 0) && (q.size() != 0);
   endtask

   task automatic idle(input logic dack);
      step(1'b0, 32'h0, 32'h0, 4'h0, dack, 32'hFFFF_FFF0);
   endtask

   initial begin
      rst_n                = 1'b0;
      lsudbus2stb_w_en     = 1'b0;
      lsudbus2stb_addr     = '0;
      lsudbus2stb_wdata    = '0;
      lsudbus2stb_sel_byte = '0;
      dcache2stb_ack       = 1'b0;
      ld_addr              = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("rst_count", stb_count, 0);
      check("rst_empty", stb_empty, 1);
      check("rst_full",  stb_full,  0);
      check("rst_req",   stb2dcache_req, 0);
      check("rst_ack",   stb2lsudbus_ack, 0);
      check("rst_addr",  stb2dcache_addr, 0);
      #2 rst_n = 1'b1;

      // Fill with the cache stalled.
      for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 1'b0, 32'h0);
      idle(1'b0);
      check("fill_count", stb_count, 4);
      check("fill_full",  stb_full, 1);
      check("fill_req",   stb2dcache_req, 1);
      check("fill_head",  stb2dcache_addr, 32'h100);

      // A push while full is dropped without an acknowledge.
      step(1'b1, 32'h200, 32'hBB, 4'hF, 1'b0, 32'h0);
      step(1'b1, 32'h200, 32'hBB, 4'hF, 1'b0, 32'h0);
      idle(1'b0);
      check("full_nack",  stb2lsudbus_ack, 0);
      check("full_count", stb_count, 4);
      check("full_head",  stb2dcache_addr, 32'h100);

      // Continuous ack drains one entry per cycle in order.
      for (int i = 0; i < 4; i++) begin
         idle(1'b1);
         check("drain_addr", stb2dcache_addr, 32'h100 + 32'(4 * i));
      end
      idle(1'b1);
      check("drain_empty", stb_empty, 1);
      check("drain_req",   stb2dcache_req, 0);
      check("drain_addr0", stb2dcache_addr, 0);

      // Push and pop in the same cycle at count 2.
      step(1'b1, 32'h300, 32'h1, 4'h3, 1'b0, 32'h0);
      step(1'b1, 32'h304, 32'h2, 4'hC, 1'b0, 32'h0);
      step(1'b1, 32'h308, 32'h3, 4'h1, 1'b1, 32'h0);
      idle(1'b0);
      check("pp_count", stb_count, 2);
      check("pp_head",  stb2dcache_addr, 32'h304);
      idle(1'b1);
      idle(1'b1);
      check("pp_last", stb2dcache_addr, 32'h308);
      idle(1'b0);

`ifdef STB_LOAD_FWD_EN
      step(1'b1, 32'h40, 32'h11, 4'hF, 1'b0, 32'h0);
      step(1'b1, 32'h40, 32'h22, 4'hF, 1'b0, 32'h0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h42);
      check("fwd_dir_hit",  fwd_hit, 1);
      check("fwd_dir_data", fwd_data, 32'h22);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h44);
      check("fwd_dir_miss", fwd_hit, 0);
      repeat (4) idle(1'b1);
`endif

      // Randomized traffic; small address pool so forwarding sees repeated words.
      for (int n = 0; n < 3000; n++) begin
         step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0), 32'($urandom_range(0, 63)));
      end

      // Reset in the middle of a handshake drops req and discards the buffer at once.
      idle(1'b0);
      step(1'b1, 32'h500, 32'h55, 4'hF, 1'b0, 32'h0);
      idle(1'b0);
      idle(1'b0);
      check("mid_req_before", stb2dcache_req, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req",   stb2dcache_req, 0);
      check("mid_rst_count", stb_count, 0);
      check("mid_rst_empty", stb_empty, 1);
      model_reset();
      #2 rst_n = 1'b1;
      repeat (5) idle(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
